sb_decoder: RTL and testbench
=============================

// Module: sb_decoder
// PURPOSE
//  System-bus address decoder between the core LSU and the memory-mapped peripherals (LED, switches, ...).
//  - Selects one slave from the upper address bits and forwards the request with the region offset only.
//  - Tracks outstanding reads and returns the selected slave's 1-cycle-late read data to the core.
//  - Flags accesses to unmapped regions and counts them.
// PARAMETERS
//  N_SLAVES  8   number of slave regions; region k = core_addr_i[31:24] == k
//  ERR_W     8   width of saturating unmapped-access counter
// PORTS
//  clk_i          in   1            system clock
//  rst_ni         in   1            asynchronous reset, active-low
//  core_req_i     in   1            core access request
//  core_we_i      in   1            1 = write, 0 = read
//  core_addr_i    in   32           byte address
//  core_wdata_i   in   32           write data
//  core_stall_o   out  1            1 = request not accepted this cycle
//  core_rvalid_o  out  1            read data valid (1-cycle pulse)
//  core_rdata_o   out  32           read data
//  core_err_o     out  1            unmapped access (1-cycle pulse, with rvalid for reads)
//  err_cnt_o      out  ERR_W        saturating count of unmapped accesses
//  slv_req_o      out  N_SLAVES     one-hot request to slaves
//  slv_we_o       out  1            write enable, broadcast
//  slv_addr_o     out  32           {8'h00, core_addr_i[23:0]}, broadcast
//  slv_wdata_o    out  32           core_wdata_i, broadcast
//  slv_rdata_i    in   32*N_SLAVES  slave k read data at [32k+31:32k], valid 1 cycle after its read req
// BEHAVIOUR
//  Reset (async, rst_ni=0): FSM=IDLE, core_rvalid_o=0, core_err_o=0, core_rdata_o=0, err_cnt_o=0,
//   sel register=0; slv_req_o=0 and core_stall_o=0 while reset is held.
//  Decode: idx = core_addr_i[31:24]; mapped = idx < N_SLAVES.
//  - slv_req_o[idx] = core_req_i & mapped & ~core_stall_o (combinational, same cycle).
//  - Unmapped accesses assert no slave request.
//  FSM states IDLE, RESP:
//  - IDLE, accepted read: latch sel=idx and map flag; go to RESP.
//  - IDLE, accepted write: slave write completes in that cycle; stay in IDLE.
//  - IDLE, unmapped write: core_err_o=1 on the next cycle.
//  - RESP: core_rvalid_o=1, lasting one cycle.
//    - Mapped: core_rdata_o = slv_rdata_i[sel] (registered sel, combinational mux).
//    - Unmapped: core_rdata_o=0 and core_err_o=1.
//  - RESP exit: core_stall_o=core_req_i, so no new request is accepted; always return to IDLE next cycle.
//  Throughput:
//   - Writes: 1 per cycle.
//   - Reads: 1 per 2 cycles.
//   - Read latency: exactly 1 cycle after acceptance.
//  err_cnt_o: increments by 1 per accepted unmapped access and saturates at all-ones.
//   It is cleared only by reset.
//  Outside RESP: core_rvalid_o=0 and core_rdata_o=0.
//  Reset asserted in RESP: pending response is dropped; no rvalid after reset release.
//  Address bits [1:0] are forwarded unchanged; alignment is the slave's concern.
// TESTING
//  - Write 0x1234 to 0x0100_0000, then read 0x0100_0000:
//    slv_req_o=8'h02 and slv_addr_o=0 on each access; rvalid 1 cycle after the read, rdata=slave1 data.
//  - Read 0x0300_0004 with slave3 returning 0xCAFE:
//    slv_req_o=8'h08, slv_addr_o=0x4; next cycle rvalid=1, rdata=0x0000CAFE, err=0.
//  - Back-to-back reads to slaves 0 and 2 with core_req_i held high:
//    second request stalled 1 cycle, then accepted; two rvalid pulses, 2 cycles apart.
//  - Read 0xFF00_0000:
//    slv_req_o=0; next cycle rvalid=1, err=1, rdata=0; err_cnt_o 0->1.
//  - 300 unmapped writes: err_cnt_o saturates at 255; no slv_req_o asserted.
//  - Assert rst_ni=0 during RESP: outputs 0 immediately; after release no rvalid, FSM in IDLE.

Source files
------------

// File: rtl/sb_decoder.sv
// System-bus address decoder: selects one of N_SLAVES regions from addr[31:24],
// returns 1-cycle-late slave read data, and flags and counts unmapped accesses.
//
// state | meaning
// IDLE  | accepting requests; writes complete in the cycle they are accepted
// RESP  | read response cycle; rvalid high, any new request is stalled
module sb_decoder #(
  parameter int N_SLAVES = 8,
  parameter int ERR_W    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [31:0]           core_addr_i,
  input  logic [31:0]           core_wdata_i,
  output logic                  core_stall_o,
  output logic                  core_rvalid_o,
  output logic [31:0]           core_rdata_o,
  output logic                  core_err_o,
  output logic [ERR_W-1:0]      err_cnt_o,
  output logic [N_SLAVES-1:0]   slv_req_o,
  output logic                  slv_we_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [32*N_SLAVES-1:0] slv_rdata_i
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             map_q, map_d;
  logic             wr_err_q, wr_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [7:0]  idx;
  logic        mapped;
  logic        in_resp;
  logic        accept;
  logic [31:0] rdata_mux;

  assign idx     = core_addr_i[31:24];
  assign mapped  = ({24'd0, idx} < 32'(N_SLAVES));
  assign in_resp = (state_q == ST_RESP);

  // rst_ni gates acceptance so nothing reaches the slaves while reset is held.
  assign core_stall_o = in_resp & core_req_i;
  assign accept       = core_req_i & ~core_stall_o & rst_ni;

  assign slv_we_o    = core_we_i;
  assign slv_addr_o  = {8'h00, core_addr_i[23:0]};
  assign slv_wdata_o = core_wdata_i;

  always_comb begin
    slv_req_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (accept && mapped && (idx == 8'(k))) begin
        slv_req_o[k] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        rdata_mux = slv_rdata_i[32*k +: 32];
      end
    end
  end

  assign core_rvalid_o = in_resp;
  assign core_rdata_o  = (in_resp && map_q) ? rdata_mux : '0;
  assign core_err_o    = (in_resp && !map_q) || wr_err_q;
  assign err_cnt_o     = err_cnt_q;

  // RESP never accepts (stall covers any request), so it always falls back to IDLE.
  always_comb begin
    state_d   = ST_IDLE;
    sel_d     = sel_q;
    map_d     = map_q;
    wr_err_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    if (!in_resp && accept && !core_we_i) begin
      state_d = ST_RESP;
      sel_d   = mapped ? idx[SEL_W-1:0] : '0;
      map_d   = mapped;
    end
    if (accept && core_we_i && !mapped) begin
      wr_err_d = 1'b1;
    end
    if (accept && !mapped && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      map_q     <= 1'b0;
      wr_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      map_q     <= map_d;
      wr_err_q  <= wr_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_sb_decoder.sv
// Bench for sb_decoder: transaction-level model plus a memory-backed slave model,
// checked every cycle, with literal checks on the directed scenarios.
module tb_sb_decoder;

  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          core_req;
  logic          core_we;
  logic [31:0]   core_addr;
  logic [31:0]   core_wdata;
  logic          core_stall;
  logic          core_rvalid;
  logic [31:0]   core_rdata;
  logic          core_err;
  logic [7:0]    err_cnt;
  logic [NS-1:0] slv_req;
  logic          slv_we;
  logic [31:0]   slv_addr;
  logic [31:0]   slv_wdata;
  logic [32*NS-1:0] slv_rdata;

  sb_decoder #(.N_SLAVES(NS), .ERR_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_stall_o(core_stall), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata), .core_err_o(core_err), .err_cnt_o(err_cnt),
    .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_addr_o(slv_addr),
    .slv_wdata_o(slv_wdata), .slv_rdata_i(slv_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] key);
    return key ^ 32'h5A5A_C3C3;
  endfunction

  // Slave model: memory per slave, read data presented one cycle after the request.
  logic [31:0] smem [logic [31:0]];
  logic [31:0] srd [NS];
  logic [31:0] nxt_rd [NS];
  logic [NS-1:0] nxt_load;

  initial for (int k = 0; k < NS; k++) srd[k] = 32'h0;

  always_comb
    for (int k = 0; k < NS; k++) slv_rdata[32*k +: 32] = srd[k];

  always @(negedge clk) begin
    logic [31:0] key;
    nxt_load = '0;
    for (int k = 0; k < NS; k++) begin
      if (slv_req[k] === 1'b1) begin
        key = {8'(k), slv_addr[23:0]};
        if (slv_we) smem[key] = slv_wdata;
        else begin
          nxt_rd[k]   = smem.exists(key) ? smem[key] : dflt(key);
          nxt_load[k] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk)
    for (int k = 0; k < NS; k++) if (nxt_load[k]) srd[k] <= nxt_rd[k];

  // Core-level model: what a correct decoder must show, from the transaction history.
  logic [31:0] shadow [logic [31:0]];
  logic        m_pend, m_pend_err, m_wr_err;
  logic [31:0] m_pend_data;
  int          m_cnt;

  always @(negedge clk) begin
    logic        stall, acc, mapped;
    logic [7:0]  idx;
    logic [31:0] key;
    logic [7:0]  exp_req;
    chk("slv_addr", slv_addr, {8'h00, core_addr[23:0]});
    chk("slv_we", {31'd0, slv_we}, {31'd0, core_we});
    chk("slv_wdata", slv_wdata, core_wdata);
    if (!rst_n) begin
      m_pend = 0; m_pend_err = 0; m_wr_err = 0; m_cnt = 0; m_pend_data = 0;
      chk("rst_slv_req", {24'd0, slv_req}, 32'd0);
      chk("rst_stall", {31'd0, core_stall}, 32'd0);
      chk("rst_rvalid", {31'd0, core_rvalid}, 32'd0);
      chk("rst_err", {31'd0, core_err}, 32'd0);
      chk("rst_rdata", core_rdata, 32'd0);
      chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    end else begin
      idx     = core_addr[31:24];
      mapped  = idx < NS;
      stall   = m_pend && core_req;
      acc     = core_req && !stall;
      exp_req = (acc && mapped) ? (8'h01 << idx) : 8'h00;
      chk("stall", {31'd0, core_stall}, {31'd0, stall});
      chk("slv_req", {24'd0, slv_req}, {24'd0, exp_req});
      chk("rvalid", {31'd0, core_rvalid}, {31'd0, m_pend});
      chk("err", {31'd0, core_err}, {31'd0, (m_pend && m_pend_err) || m_wr_err});
      chk("rdata", core_rdata, (m_pend && !m_pend_err) ? m_pend_data : 32'd0);
      chk("err_cnt", {24'd0, err_cnt}, 32'(m_cnt));
      key = {idx, core_addr[23:0]};
      m_wr_err = acc && core_we && !mapped;
      if (acc && !mapped && m_cnt < 255) m_cnt++;
      if (acc && core_we && mapped) shadow[key] = core_wdata;
      m_pend      = acc && !core_we;
      m_pend_err  = !mapped;
      m_pend_data = !mapped ? 32'd0 : (shadow.exists(key) ? shadow[key] : dflt(key));
    end
  end

  task automatic drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h0100_0000; core_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_slv_req", {24'd0, slv_req}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; core_req = 1'b0;

    // write then read slave 1
    drive(1, 1, 32'h0100_0000, 32'h0000_1234);
    @(negedge clk);
    chk("lit_wr_req", {24'd0, slv_req}, 32'h02);
    chk("lit_wr_addr", slv_addr, 32'h0);
    drive(1, 0, 32'h0100_0000, 32'h0);
    @(negedge clk);
    chk("lit_rd_req", {24'd0, slv_req}, 32'h02);
    chk("lit_rd_rvalid0", {31'd0, core_rvalid}, 32'd0);
    idle();
    @(negedge clk);
    chk("lit_rd_rvalid1", {31'd0, core_rvalid}, 32'd1);
    chk("lit_rd_data", core_rdata, 32'h0000_1234);

    // slave 3 returns 0xCAFE at offset 4
    drive(1, 1, 32'h0300_0004, 32'h0000_CAFE);
    drive(1, 0, 32'h0300_0004, 32'h0);
    @(negedge clk);
    chk("lit_s3_req", {24'd0, slv_req}, 32'h08);
    chk("lit_s3_addr", slv_addr, 32'h4);
    idle();
    @(negedge clk);
    chk("lit_s3_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("lit_s3_data", core_rdata, 32'h0000_CAFE);
    chk("lit_s3_err", {31'd0, core_err}, 32'd0);

    // back-to-back reads, request held high
    drive(1, 0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    chk("lit_b2b_req0", {24'd0, slv_req}, 32'h01);
    drive(1, 0, 32'h0200_0010, 32'h0);
    @(negedge clk);
    chk("lit_b2b_stall", {31'd0, core_stall}, 32'd1);
    chk("lit_b2b_rv0", {31'd0, core_rvalid}, 32'd1);
    chk("lit_b2b_data0", core_rdata, dflt(32'h0000_0000));
    drive(1, 0, 32'h0200_0010, 32'h0);
    @(negedge clk);
    chk("lit_b2b_req2", {24'd0, slv_req}, 32'h04);
    chk("lit_b2b_gap", {31'd0, core_rvalid}, 32'd0);
    idle();
    @(negedge clk);
    chk("lit_b2b_rv1", {31'd0, core_rvalid}, 32'd1);

    // unmapped read
    drive(1, 0, 32'hFF00_0000, 32'h0);
    @(negedge clk);
    chk("lit_um_req", {24'd0, slv_req}, 32'd0);
    chk("lit_um_cnt0", {24'd0, err_cnt}, 32'd0);
    idle();
    @(negedge clk);
    chk("lit_um_rvalid", {31'd0, core_rvalid}, 32'd1);
    chk("lit_um_err", {31'd0, core_err}, 32'd1);
    chk("lit_um_rdata", core_rdata, 32'd0);
    chk("lit_um_cnt1", {24'd0, err_cnt}, 32'd1);

    // mixed traffic, checked by the model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ix;
      ix = (i % 5 == 4) ? 8'(8'h20 + i) : 8'(i % 8);
      drive(1, (i % 3) != 1, {ix, 16'h0, 8'((i % 4) * 4)}, 32'(i) * 32'h0101_0101 + 32'd7);
    end
    idle();

    // unmapped writes until saturation
    drive(1, 1, 32'h0800_0000, 32'h1);
    idle();
    @(negedge clk);
    chk("lit_wr_err_pulse", {31'd0, core_err}, 32'd1);
    for (int i = 0; i < 300; i++)
      drive(1, 1, {8'(8'h08 + (i % 248)), 24'(i)}, 32'(i));
    idle();
    @(negedge clk);
    chk("lit_sat", {24'd0, err_cnt}, 32'd255);

    // reset during RESP
    drive(1, 0, 32'h0500_0000, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; core_req = 1'b0;
    @(negedge clk);
    chk("lit_rr_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("lit_rr_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_rr_no_rvalid", {31'd0, core_rvalid}, 32'd0);
    end
    drive(1, 1, 32'h0600_0000, 32'h77);
    @(negedge clk);
    chk("lit_rr_idle_accept", {24'd0, slv_req}, 32'h40);
    idle();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
